// File: rtl/lock_code_player.sv
// =============================================================================
// Module      : lock_code_player
// Description : Plays a CODE_LEN-bit code into a two-button lock as timed b0/b1
//               presses, then waits a bounded time for the lock to open.
//               Optional macro LOCK_CODE_PLAYER_ABORT_EN adds the abort_in port.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module lock_code_player #(
    parameter int CODE_LEN     = 6,
    parameter int PRESS_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int TIMEOUT      = 8
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                unlock_in,
`ifdef LOCK_CODE_PLAYER_ABORT_EN
    input  logic                abort_in,
`endif
    output logic                b0_out,
    output logic                b1_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [3:0]          hex_display
);

    // One shared timer covers the longest of the three timed phases.
    localparam int TMAX_PG = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TMAX    = (TMAX_PG > TIMEOUT) ? TMAX_PG : TIMEOUT;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] C_PRESS_LAST = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] C_GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] C_WAIT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    C_LEN        = 4'(CODE_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CODE_LEN-1:0] code_q,  code_d;
    logic [3:0]          hex_q,   hex_d;
    logic                pass_q,  pass_d;
    logic                b0_q,    b0_d;
    logic                b1_q,    b1_d;
    logic                w_abort;

`ifdef LOCK_CODE_PLAYER_ABORT_EN
    assign w_abort = abort_in;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        hex_d   = hex_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_PRESS;
                    code_d  = code_in;
                    hex_d   = 4'd0;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end
            end
            S_PRESS: begin
                if (w_abort) begin
                    state_d = S_FIN;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end else if (timer_q == C_PRESS_LAST) begin
                    // The MSB of code_q is always the bit being pressed.
                    state_d = S_GAP;
                    timer_d = '0;
                    hex_d   = hex_q + 4'd1;
                    code_d  = code_q << 1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (w_abort) begin
                    state_d = S_FIN;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end else if (timer_q == C_GAP_LAST) begin
                    timer_d = '0;
                    state_d = (hex_q == C_LEN) ? S_WAIT : S_PRESS;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT: begin
                // unlock_in is tested before the timeout so a tie counts as a pass.
                if (w_abort) begin
                    state_d = S_FIN;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end else if (unlock_in) begin
                    state_d = S_FIN;
                    pass_d  = 1'b1;
                    timer_d = '0;
                end else if (timer_q == C_WAIT_LAST) begin
                    state_d = S_FIN;
                    pass_d  = 1'b0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        b1_d = (state_d == S_PRESS) &&  code_d[CODE_LEN-1];
        b0_d = (state_d == S_PRESS) && !code_d[CODE_LEN-1];
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            code_q  <= '0;
            hex_q   <= 4'd0;
            pass_q  <= 1'b0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            hex_q   <= hex_d;
            pass_q  <= pass_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    assign b0_out      = b0_q;
    assign b1_out      = b1_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign pass        = pass_q;
    assign hex_display = hex_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_code_player.sv
// =============================================================================
// Module      : tb_lock_code_player
// Description : Cycle-accurate vector bench for lock_code_player (two configs).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_lock_code_player;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_in  = 1'b1;
    logic       start_in  = 1'b0;
    logic       unlock_in = 1'b0;
    logic [5:0] code_in   = 6'd0;
`ifdef LOCK_CODE_PLAYER_ABORT_EN
    logic       abort_in  = 1'b0;
`endif

    logic       b0_a, b1_a, busy_a, done_a, pass_a;
    logic [3:0] hex_a;
    logic       b0_b, b1_b, busy_b, done_b, pass_b;
    logic [3:0] hex_b;

    lock_code_player #(
        .CODE_LEN(6), .PRESS_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT(8)
    ) u_dut_a (
        .clk(clk), .reset_in(reset_in), .start_in(start_in), .code_in(code_in),
        .unlock_in(unlock_in),
`ifdef LOCK_CODE_PLAYER_ABORT_EN
        .abort_in(abort_in),
`endif
        .b0_out(b0_a), .b1_out(b1_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .hex_display(hex_a)
    );

    lock_code_player #(
        .CODE_LEN(6), .PRESS_CYCLES(3), .GAP_CYCLES(2), .TIMEOUT(4)
    ) u_dut_b (
        .clk(clk), .reset_in(reset_in), .start_in(start_in), .code_in(code_in),
        .unlock_in(unlock_in),
`ifdef LOCK_CODE_PLAYER_ABORT_EN
        .abort_in(abort_in),
`endif
        .b0_out(b0_b), .b1_out(b1_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .hex_display(hex_b)
    );

    // One record per cycle: inputs driven in that cycle and outputs expected in it.
    typedef struct packed {
        logic       sel;
        logic       chk;
        logic       rst;
        logic       start;
        logic       unlock;
        logic       abort;
        logic [5:0] code;
        logic       b0;
        logic       b1;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] hex;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic cur_sel = 1'b0;
    logic pass_st = 1'b0;
    int   hex_st  = 0;

    task automatic add(input logic rst, input logic st, input logic un, input logic ab,
                       input logic [5:0] cd, input logic chk, input logic b0,
                       input logic b1, input logic bsy, input logic dn,
                       input logic ps, input int hex);
        vec_t v;
        v.sel = cur_sel; v.chk = chk; v.rst = rst; v.start = st; v.unlock = un;
        v.abort = ab; v.code = cd; v.b0 = b0; v.b1 = b1; v.busy = bsy;
        v.done = dn; v.pass = ps; v.hex = 4'(hex);
        vecs.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            add(0, 0, 0, 0, 6'd0, 1, 0, 0, 0, 0, pass_st, hex_st);
    endtask

    task automatic do_reset();
        add(1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
        pass_st = 1'b0;
        hex_st  = 0;
    endtask

    // Expected cycle-by-cycle behaviour of one played sequence, starting at the start cycle.
    task automatic seq(input logic [5:0] code, input logic [5:0] ca, input int p,
                       input int g, input int t, input int ua, input logic hold,
                       input int poke_gap, input int rst_press, input int abort_gap);
        logic bv;
        logic u;
        add(0, 1, 0, 0, code, 1, 0, 0, 0, 0, pass_st, hex_st);
        for (int j = 0; j < 6; j++) begin
            bv = code[5-j];
            for (int k = 0; k < p; k++) begin
                if (j == rst_press && k == 0) begin
                    add(1, hold, 0, 0, ca, 1, !bv, bv, 1, 0, 0, j);
                    pass_st = 1'b0;
                    hex_st  = 0;
                    return;
                end
                add(0, hold, 0, 0, ca, 1, !bv, bv, 1, 0, 0, j);
            end
            for (int k = 0; k < g; k++) begin
                if (j == abort_gap && k == 0) begin
                    add(0, hold, 0, 1, ca, 1, 0, 0, 1, 0, 0, j + 1);
                    add(0, hold, 0, 0, ca, 1, 0, 0, 1, 1, 0, j + 1);
                    pass_st = 1'b0;
                    hex_st  = j + 1;
                    return;
                end
                add(0, hold | (j == poke_gap && k == 0), 0, 0, ca, 1, 0, 0, 1, 0, 0, j + 1);
            end
        end
        for (int w = 0; w < t; w++) begin
            u = (w == ua);
            add(0, hold, u, 0, ca, 1, 0, 0, 1, 0, 0, 6);
            if (u) break;
        end
        pass_st = (ua >= 0 && ua < t);
        add(0, hold, 0, 0, ca, 1, 0, 0, 1, 1, pass_st, 6);
        hex_st = 6;
    endtask

    task automatic compare(input int idx, input vec_t e);
        logic [8:0] got, want;
        if (e.chk) begin
            checks++;
            got  = e.sel ? {b0_b, b1_b, busy_b, done_b, pass_b, hex_b}
                         : {b0_a, b1_a, busy_a, done_a, pass_a, hex_a};
            want = {e.b0, e.b1, e.busy, e.done, e.pass, e.hex};
            if (got !== want) begin
                errors++;
                $display("FAIL cycle%0d dut_%s: got b0=%b b1=%b busy=%b done=%b pass=%b hex=%0d, want b0=%b b1=%b busy=%b done=%b pass=%b hex=%0d",
                         idx, e.sel ? "b" : "a", got[8], got[7], got[6], got[5], got[4],
                         got[3:0], want[8], want[7], want[6], want[5], want[4], want[3:0]);
            end
        end
    endtask

    initial begin
        vec_t e;

        cur_sel = 1'b0;
        do_reset();
        idle(2);
        seq(6'b101011, 6'b101011, 1, 1, 8,  0, 0, -1, -1, -1);
        idle(1);
        seq(6'b101011, 6'b101011, 1, 1, 8, -1, 0, -1, -1, -1);
        idle(1);
        seq(6'b110010, 6'b110010, 1, 1, 8,  7, 0, -1, -1, -1);
        idle(1);
        seq(6'b011100, 6'b100011, 1, 1, 8,  2, 0,  1, -1, -1);
        idle(1);
        seq(6'b101011, 6'b101011, 1, 1, 8,  0, 0, -1,  2, -1);
        idle(3);
        seq(6'b101011, 6'b101011, 1, 1, 8,  0, 0, -1, -1, -1);
        idle(1);
        seq(6'b100101, 6'b100101, 1, 1, 8,  1, 1, -1, -1, -1);
        seq(6'b010110, 6'b010110, 1, 1, 8, -1, 0, -1, -1, -1);
        idle(2);
`ifdef LOCK_CODE_PLAYER_ABORT_EN
        seq(6'b101011, 6'b101011, 1, 1, 8, -1, 0, -1, -1,  1);
        idle(2);
`endif
        cur_sel = 1'b1;
        do_reset();
        idle(1);
        seq(6'b000000, 6'b000000, 3, 2, 4, -1, 0, -1, -1, -1);
        idle(1);
        seq(6'b111000, 6'b111000, 3, 2, 4,  3, 0, -1, -1, -1);
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got empty queue, want entry at cycle %0d", i);
                end else begin
                    e = sb.pop_front();
                    compare(i, e);
                end
            end
            reset_in  = vecs[i].rst;
            start_in  = vecs[i].start;
            unlock_in = vecs[i].unlock;
            code_in   = vecs[i].code;
`ifdef LOCK_CODE_PLAYER_ABORT_EN
            abort_in  = vecs[i].abort;
`endif
            if (i + 1 < vecs.size()) sb.push_back(vecs[i+1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lock_code_player.md
LOCK_CODE_PLAYER -- requirements
Module: lock_code_player

Interface
REQ-001 Parameter CODE_LEN, default 6, number of button presses per code, legal range 1..15.
REQ-002 Parameter PRESS_CYCLES, default 1, cycles each button is held high, minimum 1.
REQ-003 Parameter GAP_CYCLES, default 1, cycles both buttons are low after each press, minimum 1.
REQ-004 Parameter TIMEOUT, default 8, cycles to wait for unlock after the last gap, minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_in  input  1  synchronous, active-high reset.
REQ-007 start_in  input  1  request to play code_in; sampled only in IDLE.
REQ-008 code_in  input  CODE_LEN  code to play, MSB first; bit 1 means b1 press, bit 0 means b0 press.
REQ-009 unlock_in  input  1  lock's open indication, sampled only in WAIT.
REQ-010 b0_out  output  1  drives the lock's b0 button input.
REQ-011 b1_out  output  1  drives the lock's b1 button input.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a sequence finishes.
REQ-014 pass  output  1  result of the last finished sequence; held until the next start.
REQ-015 hex_display  output  4  count of presses issued in the current or last sequence.

Function
REQ-016 FSM states: IDLE, PRESS, GAP, WAIT, FIN.
REQ-017 IDLE: on start_in=1, latch code_in, clear press count, clear pass, go to PRESS.
REQ-018 First press appears one cycle after the start_in cycle.
REQ-019 PRESS: the button selected by the current code bit is high for exactly PRESS_CYCLES cycles; the other button is low.
REQ-020 Leaving PRESS increments hex_display by 1 and enters GAP.
REQ-021 GAP: both buttons low for exactly GAP_CYCLES cycles.
REQ-022 End of GAP: go to PRESS with the next lower code bit, or to WAIT if CODE_LEN presses are issued.
REQ-023 b0_out and b1_out are never high in the same cycle.
REQ-024 b0_out and b1_out are driven from registers, with no combinational path from inputs.
REQ-025 WAIT: on unlock_in=1, set pass=1 and go to FIN.
REQ-026 WAIT: after TIMEOUT cycles without unlock_in, set pass=0 and go to FIN.
REQ-027 WAIT: if unlock_in rises in the same cycle the timeout expires, pass=1.
REQ-028 FIN: assert done for one cycle, then return to IDLE.
REQ-029 start_in is ignored while busy=1.
REQ-030 start_in held high continuously causes back-to-back sequences, each separated by the single IDLE cycle.
REQ-031 code_in changes after the start cycle do not affect the sequence in progress.

Reset
REQ-032 While reset_in=1 at a clock edge, the block enters IDLE with b0_out=0, b1_out=0, busy=0, done=0, pass=0, hex_display=0, and all timers and the latched code cleared.
REQ-033 Reset mid-sequence ends the sequence immediately with no done pulse.
REQ-034 Reset has priority over start_in and unlock_in.

Configuration
REQ-035 Macro LOCK_CODE_PLAYER_ABORT_EN, when defined, adds input abort_in (1 bit).
REQ-036 With the macro, abort_in=1 in PRESS, GAP or WAIT forces both buttons low next cycle, then goes to FIN with pass=0 and a normal done pulse.
REQ-037 With the macro, abort_in=1 in IDLE or FIN has no effect.
REQ-038 Without the macro, abort_in does not exist and sequences run to completion or reset.

Verification
REQ-039 Defaults; code_in=6'b101011, start at cycle 0, unlock_in=1 at first WAIT cycle -> b1,b0,b1,b0,b1,b1 pulses, each 1 cycle high and 1 cycle low, starting cycle 1; hex_display=6; done pulse with pass=1.
REQ-040 Same code with unlock_in held 0 -> WAIT lasts 8 cycles; done pulse with pass=0.
REQ-041 PRESS_CYCLES=3, GAP_CYCLES=2, code 6'b000000 -> six b0 pulses, 3 high and 2 low each; b1_out stays 0 throughout.
REQ-042 reset_in=1 during the third press -> next cycle all outputs 0, state IDLE, no done pulse; a new start plays the full code.
REQ-043 start_in pulsed during GAP and code_in changed mid-sequence -> both ignored; the sequence plays the originally latched code.
REQ-044 With LOCK_CODE_PLAYER_ABORT_EN defined, abort_in=1 during the second GAP -> buttons stay low, done pulse with pass=0, hex_display=2.
